// File: rtl/logic_rf_pkg.sv
// Shared constants for the logic register-file unit: op encodings and counter width.
package logic_rf_pkg;

    localparam int unsigned OP_W  = 2;
    localparam int unsigned OPS_W = 16;

    localparam logic [OP_W-1:0] OP_NAND = 2'b00;
    localparam logic [OP_W-1:0] OP_AND  = 2'b01;
    localparam logic [OP_W-1:0] OP_OR   = 2'b10;
    localparam logic [OP_W-1:0] OP_XOR  = 2'b11;

endpackage

// File: rtl/logic_op_unit.sv
// Combinational n-bit four-function bitwise unit (NAND/AND/OR/XOR).
module logic_op_unit
    import logic_rf_pkg::*;
#(
    parameter int unsigned n = 4
) (
    input  logic [OP_W-1:0] op_i,
    input  logic [n-1:0]    a_i,
    input  logic [n-1:0]    b_i,
    output logic [n-1:0]    res_c_o
);

    always_comb begin
        res_c_o = '0;
        unique case (op_i)
            OP_NAND: res_c_o = ~(a_i & b_i);
            OP_AND:  res_c_o = a_i & b_i;
            OP_OR:   res_c_o = a_i | b_i;
            OP_XOR:  res_c_o = a_i ^ b_i;
            default: res_c_o = '0;
        endcase
    end

endmodule

// File: rtl/logic_rf_unit.sv
// Register file with a single EX stage: operand read with EX forwarding, bitwise op,
// writeback one edge after accept, external load port and a completed-op counter.
module logic_rf_unit
    import logic_rf_pkg::*;
#(
    parameter int unsigned n     = 4,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [OP_W-1:0]  req_op,
    input  logic [AW-1:0]    req_rd,
    input  logic [AW-1:0]    req_rs1,
    input  logic [AW-1:0]    req_rs2,
    input  logic             ext_we,
    input  logic [AW-1:0]    ext_addr,
    input  logic [n-1:0]     ext_data,
    input  logic [AW-1:0]    dbg_addr,
    output logic [n-1:0]     dbg_data,
    output logic             res_valid,
    output logic [AW-1:0]    res_rd,
    output logic [n-1:0]     res_data,
    output logic [OPS_W-1:0] ops_done
);

    logic [n-1:0] rf_q [DEPTH];

    logic            ex_valid_q, ex_valid_d;
    logic [OP_W-1:0] ex_op_q, ex_op_d;
    logic [AW-1:0]   ex_rd_q, ex_rd_d;
    logic [n-1:0]    ex_a_q, ex_a_d;
    logic [n-1:0]    ex_b_q, ex_b_d;
    logic [n-1:0]    ex_res_c;

    logic             res_valid_q, res_valid_d;
    logic [AW-1:0]    res_rd_q, res_rd_d;
    logic [n-1:0]     res_data_q, res_data_d;
    logic [OPS_W-1:0] ops_q, ops_d;

    logic rs1_ok, rs2_ok, ext_ok, wb_ok, dbg_ok;
    logic [n-1:0] rd_a, rd_b;
    logic fwd_a, fwd_b, accept;

    // Address range guards only exist when the file does not fill the address space.
    generate
        if (DEPTH < (2 ** AW)) begin : g_partial
            assign rs1_ok = 32'(req_rs1)  < DEPTH;
            assign rs2_ok = 32'(req_rs2)  < DEPTH;
            assign ext_ok = 32'(ext_addr) < DEPTH;
            assign wb_ok  = 32'(ex_rd_q)  < DEPTH;
            assign dbg_ok = 32'(dbg_addr) < DEPTH;
        end else begin : g_full
            assign rs1_ok = 1'b1;
            assign rs2_ok = 1'b1;
            assign ext_ok = 1'b1;
            assign wb_ok  = 1'b1;
            assign dbg_ok = 1'b1;
        end
    endgenerate

    assign req_ready = ~ext_we;
    assign accept    = req_valid & req_ready;

    assign rd_a     = rs1_ok ? rf_q[req_rs1]  : '0;
    assign rd_b     = rs2_ok ? rf_q[req_rs2]  : '0;
    assign dbg_data = dbg_ok ? rf_q[dbg_addr] : '0;

    // An out-of-range destination is never written, so it must not be forwarded either.
    assign fwd_a = ex_valid_q & wb_ok & (ex_rd_q == req_rs1);
    assign fwd_b = ex_valid_q & wb_ok & (ex_rd_q == req_rs2);

    logic_op_unit #(.n(n)) u_op (
        .op_i    (ex_op_q),
        .a_i     (ex_a_q),
        .b_i     (ex_b_q),
        .res_c_o (ex_res_c)
    );

    always_comb begin
        ex_valid_d  = accept;
        ex_op_d     = ex_op_q;
        ex_rd_d     = ex_rd_q;
        ex_a_d      = ex_a_q;
        ex_b_d      = ex_b_q;
        res_valid_d = ex_valid_q;
        res_rd_d    = res_rd_q;
        res_data_d  = res_data_q;
        ops_d       = ops_q;
        if (accept) begin
            ex_op_d = req_op;
            ex_rd_d = req_rd;
            ex_a_d  = fwd_a ? ex_res_c : rd_a;
            ex_b_d  = fwd_b ? ex_res_c : rd_b;
        end
        if (ex_valid_q) begin
            res_rd_d   = ex_rd_q;
            res_data_d = ex_res_c;
            ops_d      = ops_q + OPS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q  <= 1'b0;
            ex_op_q     <= '0;
            ex_rd_q     <= '0;
            ex_a_q      <= '0;
            ex_b_q      <= '0;
            res_valid_q <= 1'b0;
            res_rd_q    <= '0;
            res_data_q  <= '0;
            ops_q       <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_op_q     <= ex_op_d;
            ex_rd_q     <= ex_rd_d;
            ex_a_q      <= ex_a_d;
            ex_b_q      <= ex_b_d;
            res_valid_q <= res_valid_d;
            res_rd_q    <= res_rd_d;
            res_data_q  <= res_data_d;
            ops_q       <= ops_d;
        end
    end

    // The writeback assignment comes last so it wins over an external load to the same entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            if (ext_we && ext_ok) begin
                rf_q[ext_addr] <= ext_data;
            end
            if (ex_valid_q && wb_ok) begin
                rf_q[ex_rd_q] <= ex_res_c;
            end
        end
    end

    assign res_valid = res_valid_q;
    assign res_rd    = res_rd_q;
    assign res_data  = res_data_q;
    assign ops_done  = ops_q;

endmodule

// File: tb/tb_logic_rf_unit.sv
// Directed self-checking bench for logic_rf_unit (n=4, DEPTH=8, AW=3).
module tb_logic_rf_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [2:0]  req_rd, req_rs1, req_rs2;
    logic        ext_we;
    logic [2:0]  ext_addr;
    logic [3:0]  ext_data;
    logic [2:0]  dbg_addr;
    logic [3:0]  dbg_data;
    logic        res_valid;
    logic [2:0]  res_rd;
    logic [3:0]  res_data;
    logic [15:0] ops_done;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] four_exp [4];

    logic_rf_unit #(.n(4), .DEPTH(8), .AW(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_rd    (req_rd),
        .req_rs1   (req_rs1),
        .req_rs2   (req_rs2),
        .ext_we    (ext_we),
        .ext_addr  (ext_addr),
        .ext_data  (ext_data),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .res_valid (res_valid),
        .res_rd    (res_rd),
        .res_data  (res_data),
        .ops_done  (ops_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rf(input string tag, input logic [2:0] addr, input logic [3:0] exp);
        dbg_addr = addr;
        #1;
        chk(tag, 32'(dbg_data), 32'(exp));
    endtask

    task automatic load(input logic [2:0] addr, input logic [3:0] data);
        ext_we   = 1'b1;
        ext_addr = addr;
        ext_data = data;
        step();
        ext_we   = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2);
        req_valid = 1'b1;
        req_op    = op;
        req_rd    = rd;
        req_rs1   = rs1;
        req_rs2   = rs2;
        step();
        req_valid = 1'b0;
    endtask

    initial begin
        four_exp[0] = 4'h7;
        four_exp[1] = 4'h8;
        four_exp[2] = 4'hE;
        four_exp[3] = 4'h6;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_rd    = 3'd0;
        req_rs1   = 3'd0;
        req_rs2   = 3'd0;
        ext_we    = 1'b0;
        ext_addr  = 3'd0;
        ext_data  = 4'h0;
        dbg_addr  = 3'd0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Reset defaults
        chk("rst_ops_done", 32'(ops_done), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_rd", 32'(res_rd), 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk_rf("rst_r0", 3'd0, 4'h0);
        chk_rf("rst_r7", 3'd7, 4'h0);

        // Load then NAND; req_ready must drop during an external write
        ext_we = 1'b1; ext_addr = 3'd1; ext_data = 4'b1100;
        #1;
        chk("ext_we_ready_low", 32'(req_ready), 32'd0);
        step();
        load(3'd2, 4'b1010);
        ext_we = 1'b0;
        chk_rf("load_r1", 3'd1, 4'b1100);
        issue(2'b00, 3'd3, 3'd1, 3'd2);
        chk("nand_not_yet", 32'(res_valid), 32'd0);
        step();
        chk("nand_res_valid", 32'(res_valid), 32'd1);
        chk("nand_res_rd", 32'(res_rd), 32'd3);
        chk("nand_res_data", 32'(res_data), 32'b0111);
        chk("nand_ops_done", 32'(ops_done), 32'd1);
        chk_rf("nand_r3", 3'd3, 4'b0111);
        step();
        chk("nand_pulse_low", 32'(res_valid), 32'd0);
        chk("nand_data_hold", 32'(res_data), 32'b0111);

        // Back-to-back with forwarding of R4 into the XOR
        load(3'd1, 4'b0011);
        load(3'd2, 4'b0101);
        req_valid = 1'b1; req_op = 2'b01; req_rd = 3'd4; req_rs1 = 3'd1; req_rs2 = 3'd2;
        step();
        req_op = 2'b11; req_rd = 3'd5; req_rs1 = 3'd4; req_rs2 = 3'd2;
        step();
        req_valid = 1'b0;
        chk("b2b_and_rd", 32'(res_rd), 32'd4);
        chk("b2b_and_data", 32'(res_data), 32'b0001);
        step();
        chk("b2b_xor_valid", 32'(res_valid), 32'd1);
        chk("b2b_xor_rd", 32'(res_rd), 32'd5);
        chk("b2b_xor_data", 32'(res_data), 32'b0100);
        chk("b2b_ops_done", 32'(ops_done), 32'd3);
        chk_rf("b2b_r4", 3'd4, 4'b0001);
        chk_rf("b2b_r5", 3'd5, 4'b0100);

        // All four ops on C / A
        load(3'd1, 4'hC);
        load(3'd2, 4'hA);
        for (int i = 0; i < 4; i++) begin
            issue(2'(i), 3'd6, 3'd1, 3'd2);
            step();
            chk($sformatf("op%0d_data", i), 32'(res_data), 32'(four_exp[i]));
        end
        chk("four_ops_done", 32'(ops_done), 32'd7);

        // External write to the same register as an in-flight OR: writeback wins
        issue(2'b10, 3'd6, 3'd1, 3'd2);
        ext_we = 1'b1; ext_addr = 3'd6; ext_data = 4'h3;
        #1;
        chk("coll_ready_low", 32'(req_ready), 32'd0);
        step();
        ext_we = 1'b0;
        chk("coll_res_valid", 32'(res_valid), 32'd1);
        chk_rf("coll_same_r6", 3'd6, 4'hE);

        // External write to a different register in the writeback cycle: both land
        issue(2'b10, 3'd7, 3'd1, 3'd2);
        ext_we = 1'b1; ext_addr = 3'd0; ext_data = 4'h5;
        step();
        ext_we = 1'b0;
        chk_rf("coll_diff_r7", 3'd7, 4'hE);
        chk_rf("coll_diff_r0", 3'd0, 4'h5);

        // Same-register ops, then forwarding into both operands
        issue(2'b11, 3'd3, 3'd3, 3'd3);
        step();
        chk("same_xor_data", 32'(res_data), 32'h0);
        chk_rf("same_r3", 3'd3, 4'h0);
        req_valid = 1'b1; req_op = 2'b10; req_rd = 3'd5; req_rs1 = 3'd5; req_rs2 = 3'd1;
        step();
        req_op = 2'b00; req_rd = 3'd5; req_rs1 = 3'd5; req_rs2 = 3'd5;
        step();
        req_valid = 1'b0;
        chk("same_or_data", 32'(res_data), 32'hC);
        step();
        chk("same_nand_data", 32'(res_data), 32'h3);
        chk_rf("same_r5", 3'd5, 4'h3);
        chk("same_ops_done", 32'(ops_done), 32'd12);

        // Reset while an op is in flight: no writeback, everything cleared
        issue(2'b01, 3'd2, 3'd1, 3'd1);
        chk("pre_rst_ops", 32'(ops_done), 32'd12);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ops", 32'(ops_done), 32'd0);
        chk("mid_rst_valid", 32'(res_valid), 32'd0);
        chk("mid_rst_data", 32'(res_data), 32'd0);
        chk_rf("mid_rst_r1", 3'd1, 4'h0);
        chk_rf("mid_rst_r5", 3'd5, 4'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_valid", 32'(res_valid), 32'd0);
        step();
        chk("post_rst_valid2", 32'(res_valid), 32'd0);
        chk("post_rst_ops", 32'(ops_done), 32'd0);
        chk_rf("post_rst_r2", 3'd2, 4'h0);

        // Counter wrap: 65535 back-to-back ops, then one more
        req_valid = 1'b1; req_op = 2'b00; req_rd = 3'd6; req_rs1 = 3'd0; req_rs2 = 3'd0;
        repeat (65535) step();
        req_valid = 1'b0;
        step();
        chk("wrap_ffff", 32'(ops_done), 32'hFFFF);
        issue(2'b00, 3'd6, 3'd0, 3'd0);
        step();
        chk("wrap_valid", 32'(res_valid), 32'd1);
        chk("wrap_zero", 32'(ops_done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
